// File: rtl/stdout_uart_bridge.sv
// rtl/stdout_uart_bridge.sv - CPU stdout capture into a small FIFO, serialised as 8N1 UART on Tx
module stdout_uart_bridge #(
    parameter logic [27:0] CLKS_PER_BIT = 28'd434,
    parameter int          DEPTH        = 8,
    parameter bit          ADD_CR       = 1'b1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Cout,
    input  logic [7:0]               stdout,
    output logic                     CioAcq,
    output logic                     Tx,
    output logic [$clog2(DEPTH):0]   FifoLevel,
    output logic                     Busy
);
    localparam int              PW       = $clog2(DEPTH);
    localparam int              LW       = PW + 1;
    localparam logic [LW-1:0]   FULL     = LW'(DEPTH);
    localparam logic [27:0]     BIT_LAST = CLKS_PER_BIT - 28'd1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [27:0]     cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [LW-1:0]   level_q, level_d;
    logic            armed_q, armed_d;
    logic            cr_done_q, cr_done_d;
    logic            ack_q, ack_d;
    logic [7:0]      fifo_mem [DEPTH];
    logic            push, pop, take, bit_end;
    logic [7:0]      head_byte;

    assign head_byte = fifo_mem[head_q];
    assign push      = Cout && armed_q && (level_q != FULL);
    assign bit_end   = (cnt_q == BIT_LAST);

    // Transmit FSM; a take either loads a CR in front of an LF (no pop) or pops the head.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 28'd1;
        idx_d     = idx_q;
        sh_d      = sh_q;
        cr_done_d = cr_done_q;
        take      = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                take  = (level_q != '0);
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    take    = (level_q != '0);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = START;
            cnt_d   = '0;
            if (ADD_CR && (head_byte == 8'h0A) && !cr_done_q) begin
                sh_d      = 8'h0D;
                cr_done_d = 1'b1;
            end else begin
                sh_d      = head_byte;
                cr_done_d = 1'b0;
                pop       = 1'b1;
            end
        end
    end

    always_comb begin
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        head_d  = pop ? head_q + PW'(1) : head_q;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end
        // One acceptance per Cout high period: re-arm only once Cout is seen low.
        armed_d = armed_q;
        if (push) begin
            armed_d = 1'b0;
        end else if (!Cout) begin
            armed_d = 1'b1;
        end
        ack_d = push;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            level_q   <= '0;
            armed_q   <= 1'b1;
            cr_done_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            level_q   <= level_d;
            armed_q   <= armed_d;
            cr_done_q <= cr_done_d;
            ack_q     <= ack_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[tail_q] <= stdout;
        end
    end

    assign CioAcq    = ack_q;
    assign FifoLevel = level_q;
    assign Busy      = (level_q != '0) || (state_q != IDLE);
    assign Tx        = (state_q == START) ? 1'b0 :
                       (state_q == DATA)  ? sh_q[idx_q] : 1'b1;
endmodule

// File: tb/tb_stdout_uart_bridge.sv
// tb/tb_stdout_uart_bridge.sv - scoreboard bench for stdout_uart_bridge (CR and no-CR instances)
module tb_stdout_uart_bridge;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cout = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ack, tx, busy;
    logic [2:0] level;
    logic       ack_n, tx_n, busy_n;
    logic [2:0] level_n;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_n_q[$];
    int starts[$];

    stdout_uart_bridge #(.CLKS_PER_BIT(28'd4), .DEPTH(4), .ADD_CR(1'b1)) dut (
        .Clk(clk), .Rst(rst), .Cout(cout), .stdout(din),
        .CioAcq(ack), .Tx(tx), .FifoLevel(level), .Busy(busy));

    stdout_uart_bridge #(.CLKS_PER_BIT(28'd4), .DEPTH(4), .ADD_CR(1'b0)) dut_nocr (
        .Clk(clk), .Rst(rst), .Cout(cout), .stdout(din),
        .CioAcq(ack_n), .Tx(tx_n), .FifoLevel(level_n), .Busy(busy_n));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] b);
        if (b == 8'h0A) exp_q.push_back(8'h0D);
        exp_q.push_back(b);
        exp_n_q.push_back(b);
    endtask

    task automatic pulse(input logic [7:0] b);
        @(negedge clk);
        cout = 1'b1;
        din  = b;
        push_exp(b);
        @(negedge clk);
        cout = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || busy_n) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        expect_eq(tag, 32'(n < 3000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // UART receivers: decode each frame from the first low cycle and score it.
    logic     mon_act [2];
    int       mon_t   [2];
    logic [7:0] mon_sh [2];
    initial begin
        logic       txk;
        logic [31:0] e;
        mon_act[0] = 1'b0;
        mon_act[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                txk = (k == 0) ? tx : tx_n;
                if (rst) begin
                    mon_act[k] = 1'b0;
                end else if (!mon_act[k]) begin
                    if (!txk) begin
                        mon_act[k] = 1'b1;
                        mon_t[k]   = 0;
                        if (k == 0) starts.push_back(cyc);
                    end
                end else begin
                    mon_t[k]++;
                    if (mon_t[k] == 2) expect_eq("start_bit", 32'(txk), 32'd0);
                    if (mon_t[k] >= 6 && mon_t[k] <= 34 && ((mon_t[k] - 6) % 4) == 0)
                        mon_sh[k] = {txk, mon_sh[k][7:1]};
                    if (mon_t[k] == 38) begin
                        expect_eq("stop_bit", 32'(txk), 32'd1);
                        if (k == 0) e = (exp_q.size() > 0) ? {24'b0, exp_q.pop_front()} : 32'hDEAD_BEEF;
                        else        e = (exp_n_q.size() > 0) ? {24'b0, exp_n_q.pop_front()} : 32'hDEAD_BEEF;
                        expect_eq((k == 0) ? "rx_byte" : "rx_byte_nocr", {24'b0, mon_sh[k]}, e);
                    end
                    if (mon_t[k] == 39) mon_act[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int acks_n;
        int base;
        int n;

        // Reset held while Cout toggles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cout = ~cout;
            din  = 8'h5A;
            expect_eq("rst_tx", 32'(tx), 32'd1);
            expect_eq("rst_ack", 32'(ack), 32'd0);
            expect_eq("rst_level", 32'(level), 32'd0);
            expect_eq("rst_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        cout = 1'b0;
        rst  = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte: latency and frame timing
        @(negedge clk);
        cout = 1'b1;
        din  = 8'h41;
        push_exp(8'h41);
        @(negedge clk);
        cout = 1'b0;
        expect_eq("t2_ack_a1", 32'(ack), 32'd1);
        expect_eq("t2_level_a1", 32'(level), 32'd1);
        expect_eq("t2_tx_a1", 32'(tx), 32'd1);
        @(negedge clk);
        expect_eq("t2_ack_a2", 32'(ack), 32'd0);
        expect_eq("t2_level_a2", 32'(level), 32'd0);
        expect_eq("t2_tx_a2", 32'(tx), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_eq("t2_start", 32'(tx), 32'd0);
        end
        repeat (36) @(negedge clk);
        expect_eq("t2_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        expect_eq("t2_busy_fall", 32'(busy), 32'd0);
        wait_idle("t2_idle");

        // Held request: one acceptance
        acks = 0;
        acks_n = 0;
        @(negedge clk);
        cout = 1'b1;
        din  = 8'h42;
        push_exp(8'h42);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 19) cout = 1'b0;
            acks   += int'(ack);
            acks_n += int'(ack_n);
        end
        expect_eq("t3_acks", acks, 1);
        expect_eq("t3_acks_nocr", acks_n, 1);
        wait_idle("t3_idle");

        // Full FIFO, held request, back-to-back frames
        base = starts.size();
        for (int i = 0; i < 5; i++) pulse(8'h31 + 8'(i));
        expect_eq("t4_level_full", 32'(level), 32'd4);
        @(negedge clk);
        cout = 1'b1;
        din  = 8'h36;
        push_exp(8'h36);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_eq("t4_no_ack_full", 32'(ack), 32'd0);
            expect_eq("t4_level_hold", 32'(level), 32'd4);
        end
        n = 0;
        while (!ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        expect_eq("t4_ack_after_pop", 32'(ack), 32'd1);
        cout = 1'b0;
        wait_idle("t4_idle");
        expect_eq("t4_frames", starts.size() - base, 6);
        for (int i = base; i < base + 5 && i + 1 < starts.size(); i++)
            expect_eq("t4_b2b_gap", starts[i + 1] - starts[i], 40);

        // CR expansion
        @(negedge clk);
        cout = 1'b1;
        din  = 8'h0A;
        push_exp(8'h0A);
        @(negedge clk);
        cout = 1'b0;
        expect_eq("t5_level_a1", 32'(level), 32'd1);
        @(negedge clk);
        expect_eq("t5_level_cr", 32'(level), 32'd1);
        expect_eq("t5_level_nocr", 32'(level_n), 32'd0);
        repeat (39) @(negedge clk);
        expect_eq("t5_level_cr_stop", 32'(level), 32'd1);
        @(negedge clk);
        expect_eq("t5_level_lf", 32'(level), 32'd0);
        expect_eq("t5_tx_lf_start", 32'(tx), 32'd0);
        wait_idle("t5_idle");

        // Reset mid-frame
        @(negedge clk);
        cout = 1'b1;
        din  = 8'h11;
        push_exp(8'h11);
        @(negedge clk);
        cout = 1'b0;
        @(negedge clk);
        cout = 1'b1;
        din  = 8'h22;
        push_exp(8'h22);
        @(negedge clk);
        cout = 1'b0;
        @(negedge clk);
        cout = 1'b1;
        din  = 8'h33;
        push_exp(8'h33);
        @(negedge clk);
        cout = 1'b0;
        repeat (14) @(negedge clk);
        expect_eq("t6_level_pre", 32'(level), 32'd2);
        rst = 1'b1;
        #1;
        expect_eq("t6_tx_rst", 32'(tx), 32'd1);
        expect_eq("t6_level_rst", 32'(level), 32'd0);
        expect_eq("t6_busy_rst", 32'(busy), 32'd0);
        exp_q.delete();
        exp_n_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_eq("t6_tx_idle", 32'(tx), 32'd1);
        pulse(8'h55);
        wait_idle("t6_idle");

        expect_eq("sb_drain", exp_q.size(), 0);
        expect_eq("sb_drain_nocr", exp_n_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
